clk_div_phase: RTL and testbench

- Parametrised multi-channel clock-enable/divided-clock generator driven by one shared modulo-DIV counter.
- Each channel produces a registered square wave of programmable high time and programmable phase delay in clk cycles.
- Divisor, high time and delays are runtime-reloadable and take effect glitch-free at the period boundary.
- Feeds slow peripheral clocks (e.g. I2C/SPI timing) and their delayed sampling copies.

---
 rtl/clk_div_phase.sv | 108 ++++++++++
 tb/tb_clk_div_phase.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_phase.sv
// Multi-channel divided-clock generator: one shared modulo-div counter drives N_CH
// registered square waves with programmable high time and phase delay.
module clk_div_phase #(
  parameter int                      WIDTH    = 10,
  parameter int                      N_CH     = 2,
  parameter int                      DEF_DIV  = 950,
  parameter int                      DEF_HIGH = 475,
  parameter logic [N_CH*WIDTH-1:0]   DEF_DLY  = {10'd240, 10'd0}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0]       cfg_div,
  input  logic [WIDTH-1:0]       cfg_high,
  input  logic [N_CH*WIDTH-1:0]  cfg_dly,
  input  logic                   cfg_load,
  output logic                   cfg_busy,
  output logic                   cfg_ack,
  output logic                   cfg_err,
  output logic [N_CH-1:0]        o_clk,
  output logic                   o_sync
);

  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      div_q, div_d, high_q, high_d;
  logic [N_CH*WIDTH-1:0] dly_q, dly_d;
  logic [WIDTH-1:0]      pdiv_q, pdiv_d, phigh_q, phigh_d;
  logic [N_CH*WIDTH-1:0] pdly_q, pdly_d;
  logic                  busy_q, busy_d, ack_q, ack_d, err_q, err_d, sync_q, sync_d;
  logic [N_CH-1:0]       oclk_q, oclk_d;
  logic                  wrap, apply, cfg_ok, load_ok;

  // Position within the period relative to a channel's delayed start; the extra
  // bit keeps cnt + div from overflowing before the delay is removed.
  function automatic logic [WIDTH:0] phase(input logic [WIDTH-1:0] c,
                                           input logic [WIDTH-1:0] d,
                                           input logic [WIDTH-1:0] dl);
    if (c >= dl) return {1'b0, c} - {1'b0, dl};
    return {1'b0, c} + {1'b0, d} - {1'b0, dl};
  endfunction

  always_comb begin
    cfg_ok = (cfg_div >= WIDTH'(2));
    for (int k = 0; k < N_CH; k++) begin
      if (cfg_dly[k*WIDTH +: WIDTH] >= cfg_div) cfg_ok = 1'b0;
    end
  end

  assign load_ok = cfg_load && cfg_ok;
  assign wrap    = en && (cnt_q >= div_q - WIDTH'(1));
  // While stopped there is no period boundary to wait for, so apply immediately.
  assign apply   = busy_q && (wrap || !en);

  always_comb begin
    cnt_d   = (!en || wrap) ? '0 : cnt_q + WIDTH'(1);
    div_d   = apply ? pdiv_q  : div_q;
    high_d  = apply ? phigh_q : high_q;
    dly_d   = apply ? pdly_q  : dly_q;
    pdiv_d  = load_ok ? cfg_div  : pdiv_q;
    phigh_d = load_ok ? cfg_high : phigh_q;
    pdly_d  = load_ok ? cfg_dly  : pdly_q;
    busy_d  = load_ok ? 1'b1 : (apply ? 1'b0 : busy_q);
    ack_d   = apply;
    err_d   = cfg_load && !cfg_ok;
    sync_d  = wrap;
    for (int k = 0; k < N_CH; k++) begin
      oclk_d[k] = en && (phase(cnt_q, div_q, dly_q[k*WIDTH +: WIDTH]) < {1'b0, high_q});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= WIDTH'(DEF_DIV);
      high_q <= WIDTH'(DEF_HIGH);
      dly_q  <= DEF_DLY;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      sync_q <= 1'b0;
      oclk_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      high_q <= high_d;
      dly_q  <= dly_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      sync_q <= sync_d;
      oclk_q <= oclk_d;
    end
  end

  // Pending values are only meaningful while busy_q is set, so they need no reset.
  always_ff @(posedge clk) begin
    pdiv_q  <= pdiv_d;
    phigh_q <= phigh_d;
    pdly_q  <= pdly_d;
  end

  assign cfg_busy = busy_q;
  assign cfg_ack  = ack_q;
  assign cfg_err  = err_q;
  assign o_sync   = sync_q;
  assign o_clk    = oclk_q;

endmodule

// File: tb/tb_clk_div_phase.sv
// Bench for clk_div_phase: modular-arithmetic reference model plus targeted
// waveform-shape checks for defaults, reloads, illegal loads and edge cases.
module tb_clk_div_phase;
  localparam int W  = 10;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst, en, cfg_load;
  logic [W-1:0]  cfg_div, cfg_high;
  logic [NC*W-1:0] cfg_dly;
  logic          cfg_busy, cfg_ack, cfg_err, o_sync;
  logic [NC-1:0] o_clk;

  int checks = 0, failures = 0, cyc = 0;

  clk_div_phase dut (
    .clk(clk), .rst(rst), .en(en), .cfg_div(cfg_div), .cfg_high(cfg_high),
    .cfg_dly(cfg_dly), .cfg_load(cfg_load), .cfg_busy(cfg_busy), .cfg_ack(cfg_ack),
    .cfg_err(cfg_err), .o_clk(o_clk), .o_sync(o_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: time within the period, active/pending settings as integers.
  int  m_cnt, m_div, m_high, p_div, p_high;
  int  m_dly [NC];
  int  p_dly [NC];
  bit  m_pv, mw, ma, mok;
  logic [NC-1:0] e_clk;
  logic e_sync, e_busy, e_ack, e_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_div = 950; m_high = 475; m_dly[0] = 0; m_dly[1] = 240; m_pv = 0;
      e_clk = '0; e_sync = 0; e_busy = 0; e_ack = 0; e_err = 0;
    end else begin
      mw = en && (m_cnt == m_div - 1);
      ma = m_pv && (!en || mw);
      for (int k = 0; k < NC; k++)
        e_clk[k] = en && (((m_cnt - m_dly[k] + m_div) % m_div) < m_high);
      e_sync = mw;
      e_ack  = ma;
      mok = (int'(cfg_div) >= 2);
      for (int k = 0; k < NC; k++)
        if (int'(cfg_dly[k*W +: W]) >= int'(cfg_div)) mok = 0;
      e_err = cfg_load && !mok;
      m_cnt = (en && !mw) ? m_cnt + 1 : 0;
      if (ma) begin
        m_div = p_div; m_high = p_high; m_dly = p_dly; m_pv = 0;
      end
      if (cfg_load && mok) begin
        p_div = int'(cfg_div); p_high = int'(cfg_high);
        for (int k = 0; k < NC; k++) p_dly[k] = int'(cfg_dly[k*W +: W]);
        m_pv = 1;
      end
      e_busy = m_pv;
    end
  end

  logic [NC+3:0] obs, expv;
  assign obs  = {o_clk, o_sync, cfg_busy, cfg_ack, cfg_err};
  assign expv = {e_clk, e_sync, e_busy, e_ack, e_err};

  task automatic set_cfg(input int d, input int h, input int d1, input int d0);
    cfg_div  = W'(d);
    cfg_high = W'(h);
    cfg_dly  = {W'(d1), W'(d0)};
    cfg_load = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1; en = 0; cfg_load = 0; cfg_div = '0; cfg_high = '0; cfg_dly = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset got=%b exp=0", obs); end
    rst = 0;
  endtask

  task automatic test_defaults;
    int r0 = -1, f0 = -1, r0b = -1, r1 = -1, s1 = -1, s2 = -1;
    logic [NC-1:0] prev = '0;
    en = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL defaults cyc=%0d got=%b exp=%b", cyc, obs, expv); end
      if (o_clk[0] && !prev[0]) begin if (r0 < 0) r0 = i; else if (r0b < 0) r0b = i; end
      if (!o_clk[0] && prev[0] && f0 < 0) f0 = i;
      if (o_clk[1] && !prev[1] && r1 < 0) r1 = i;
      if (o_sync) begin if (s1 < 0) s1 = i; else if (s2 < 0) s2 = i; end
      prev = o_clk;
    end
    checks++; if (f0 - r0 != 475)  begin failures++; $display("FAIL def_high got=%0d exp=475", f0 - r0); end
    checks++; if (r0b - r0 != 950) begin failures++; $display("FAIL def_period got=%0d exp=950", r0b - r0); end
    checks++; if (r1 - r0 != 240)  begin failures++; $display("FAIL def_ch1_offset got=%0d exp=240", r1 - r0); end
    checks++; if (s2 - s1 != 950)  begin failures++; $display("FAIL def_sync_period got=%0d exp=950", s2 - s1); end
    checks++; if (s1 != 949)       begin failures++; $display("FAIL def_first_sync got=%0d exp=949", s1); end
  endtask

  task automatic test_reload;
    bit found = 0;
    int acks = 0;
    repeat (7) @(negedge clk);
    set_cfg(10, 3, 5, 0);
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      cfg_load = 0;
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL reload cyc=%0d got=%b exp=%b", cyc, obs, expv); end
      if (cfg_ack) found = 1;
      else begin
        checks++;
        if (cfg_busy !== 1'b1) begin failures++; $display("FAIL reload_busy cyc=%0d got=%b exp=1", cyc, cfg_busy); end
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL reload_ack_timeout got=0 exp=1"); end
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (cfg_ack) acks++;
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL reload_run cyc=%0d got=%b exp=%b", cyc, obs, expv); end
      checks++;
      if (o_clk !== {1'(((j + 5) % 10) < 3), 1'((j % 10) < 3)}) begin
        failures++; $display("FAIL reload_shape j=%0d got=%b", j, o_clk);
      end
    end
    checks++; if (acks != 0 || cfg_busy !== 1'b0) begin failures++; $display("FAIL reload_single_ack extra=%0d busy=%b exp=0", acks, cfg_busy); end
  endtask

  task automatic test_back_to_back_wrap;
    bit found = 0;
    int acks = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (o_sync) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL b2b_sync_timeout got=0 exp=1"); end
    set_cfg(12, 2, 4, 0);
    @(negedge clk);
    set_cfg(8, 4, 6, 0);
    @(negedge clk);
    cfg_load = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs, expv); end
      if (cfg_ack) begin found = 1; acks++; end
    end
    checks++; if (!found) begin failures++; $display("FAIL b2b_ack_timeout got=0 exp=1"); end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (cfg_ack) acks++;
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL wrap_run cyc=%0d got=%b exp=%b", cyc, obs, expv); end
      checks++;
      if (o_clk !== {1'((j % 8) >= 6 || (j % 8) <= 1), 1'((j % 8) < 4)}) begin
        failures++; $display("FAIL wrap_shape j=%0d got=%b", j, o_clk);
      end
    end
    checks++; if (acks != 1) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=1", acks); end
  endtask

  task automatic test_illegal;
    int errs, busies, syncs;
    for (int t = 0; t < 2; t++) begin
      errs = 0; busies = 0;
      repeat (3) @(negedge clk);
      if (t == 0) set_cfg(1, 4, 0, 0); else set_cfg(8, 4, 8, 0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        cfg_load = 0;
        if (cfg_err) errs++;
        if (cfg_busy) busies++;
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL illegal cyc=%0d got=%b exp=%b", cyc, obs, expv); end
      end
      checks++; if (errs != 1)   begin failures++; $display("FAIL illegal_err t=%0d got=%0d exp=1", t, errs); end
      checks++; if (busies != 0) begin failures++; $display("FAIL illegal_busy t=%0d got=%0d exp=0", t, busies); end
    end
    syncs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (o_sync) syncs++;
    end
    checks++; if (syncs != 2) begin failures++; $display("FAIL illegal_timing syncs got=%0d exp=2", syncs); end
  endtask

  task automatic test_edge;
    bit found;
    for (int t = 0; t < 2; t++) begin
      set_cfg(16, (t == 0) ? 0 : 20, 3, 0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        cfg_load = 0;
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL edge cyc=%0d got=%b exp=%b", cyc, obs, expv); end
        if (cfg_ack) found = 1;
      end
      checks++; if (!found) begin failures++; $display("FAIL edge_ack_timeout t=%0d", t); end
      for (int j = 0; j < 32; j++) begin
        @(negedge clk);
        checks++;
        if (o_clk !== ((t == 0) ? 2'b00 : 2'b11)) begin
          failures++; $display("FAIL edge_level t=%0d j=%0d got=%b", t, j, o_clk);
        end
      end
    end
    en = 0;
    @(negedge clk);
    checks++; if (o_clk !== 2'b00) begin failures++; $display("FAIL en_drop got=%b exp=00", o_clk); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL en_low cyc=%0d got=%b exp=%b", cyc, obs, expv); end
    end
  endtask

  task automatic test_rst_mid;
    int highs = 0, s1 = -1;
    en = 1;
    repeat (5) @(negedge clk);
    set_cfg(20, 5, 2, 0);
    @(negedge clk);
    cfg_load = 0;
    checks++; if (cfg_busy !== 1'b1 || o_clk !== 2'b11) begin failures++; $display("FAIL rst_pre busy=%b clk=%b exp=1,11", cfg_busy, o_clk); end
    #2 rst = 1;
    #1;
    checks++; if (obs !== '0) begin failures++; $display("FAIL rst_async got=%b exp=0", obs); end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL rst_after cyc=%0d got=%b exp=%b", cyc, obs, expv); end
      if (i < 950 && o_clk[0]) highs++;
      if (o_sync && s1 < 0) s1 = i;
    end
    checks++; if (highs != 475) begin failures++; $display("FAIL rst_def_high got=%0d exp=475", highs); end
    checks++; if (s1 != 949)    begin failures++; $display("FAIL rst_def_sync got=%0d exp=949", s1); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, expv); end
      cfg_load = ($urandom_range(0, 7) == 0);
      cfg_div  = W'($urandom_range(0, 20));
      cfg_high = W'($urandom_range(0, 24));
      cfg_dly  = {W'($urandom_range(0, 16)), W'($urandom_range(0, 16))};
      if ($urandom_range(0, 63) == 0) en = ~en;
    end
    cfg_load = 0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_reload();
    test_back_to_back_wrap();
    test_illegal();
    test_edge();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
